reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised, clocked general-purpose register file with an integrated scoreboard.
//  Successor to the single-write, two-read register file: adds
//   - configurable width, depth and read-port count
//   - registered reads with write-to-read bypass
//   - per-register pending bits for multi-cycle producers
//  Sits between decode/issue (read + issue) and writeback (write + clear).
// PARAMETERS
//  WIDTH  32  data bits per register
//  DEPTH  32  number of registers (power of 2, >=2); AW = $clog2(DEPTH) is a localparam
//  NREAD  2   number of independent read ports (1..4)
// PORTS
//  clk        in   1           rising-edge clock
//  rst        in   1           asynchronous, active-high reset
//  rd_req     in   NREAD       per-port read request
//  rd_addr    in   NREAD*AW    port i address in [i*AW +: AW]
//  rd_busy    out  NREAD       comb: port i target pending, request not accepted
//  rd_valid   out  NREAD       registered: port i data valid this cycle
//  rd_data    out  NREAD*WIDTH registered: port i data in [i*WIDTH +: WIDTH]
//  wb_en      in   1           writeback: write wb_data and clear pending of wb_addr
//  wb_addr    in   AW          writeback destination
//  wb_data    in   WIDTH       writeback data
//  iss_en     in   1           issue: mark iss_addr pending
//  iss_addr   in   AW          issue destination
//  iss_busy   out  1           comb: issue refused, destination already pending
//  flush      in   1           sync: clear all pending bits, register data kept
//  pend_vec   out  DEPTH       registered pending bits; bit 0 always 0
// BEHAVIOUR
//  Reset (async, rst=1)
//   - all registers = 0, pend_vec = 0
//   - rd_valid = 0, rd_data = 0
//   - effective immediately; takes precedence over any in-flight request
//  Register 0
//   - always reads 0, never pending
//   - wb_en or iss_en to address 0 ignored (iss_busy=0, accepted as no-op)
//  Write
//   - wb_en: reg[wb_addr] <= wb_data at the edge
//   - clears pend[wb_addr] unless re-issued the same cycle
//   - wb_en to a non-pending register is legal (plain write)
//  Read (1-cycle latency)
//   - port i accepted when rd_req[i] & ~rd_busy[i]
//   - next cycle: rd_valid[i]=1, rd_data[i] = value of reg[rd_addr[i]] after this edge's write
//   - i.e. same-cycle wb_en to that address bypasses: new wb_data returned
//   - not accepted / no request: rd_valid[i]=0 next cycle, rd_data[i] holds last value
//   - rd_busy[i] = rd_req[i] & pend[rd_addr[i]] & ~(wb_en & wb_addr==rd_addr[i])
//   - same-cycle iss_en to the read address does not block the read (old value returned)
//   - ports fully independent; any ports may share an address
//  Issue / scoreboard
//   - iss_busy = iss_en & pend[iss_addr] & ~(wb_en & wb_addr==iss_addr)
//   - accepted issue sets pend[iss_addr] at the edge
//   - iss and wb same address same cycle: data written, pending remains set (issue wins)
//   - refused issue changes no state; issuer must hold and retry
//  Flush
//   - flush=1 clears all pending bits at the edge
//   - overrides same-cycle issue (not set) and makes it non-busy
//   - wb_en still writes data; reads proceed normally
//  Width rules
//   - no arithmetic; pend_vec[0] tied 0
//   - addresses are AW bits, every encoding valid
// TESTING
//  1. Reset then read ports 0/1 of r5,r0 -> next cycle rd_valid=2'b11, rd_data=0,0; pend_vec=0
//  2. wb r3=32'hDEADBEEF, next cycle read r3 -> following cycle rd_data=32'hDEADBEEF
//     Same-cycle wb r7=32'h1234 with read r7 -> rd_data=32'h1234 (bypass)
//  3. Issue r4 -> pend_vec[4]=1
//     Read r4 -> rd_busy=1, rd_valid=0 next cycle
//     Re-issue r4 -> iss_busy=1
//     wb r4=32'h55 with read r4 same cycle -> rd_busy=0, next rd_data=32'h55, pend_vec[4]=0
//  4. Same cycle iss r9 + wb r9=32'hA -> pend_vec[9]=1; wb r9=32'hB -> pend_vec[9]=0, read r9 = 32'hB
//  5. wb r0=32'hFFFF_FFFF and iss r0 -> iss_busy=0, pend_vec[0]=0, read r0 = 0
//  6. Pend r2,r6; flush with iss r8 -> pend_vec=0
//     Assert rst mid-read -> rd_valid=0, rd_data=0 immediately; r3 read after reset = 0

Source files
------------

// File: rtl/reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_sb
//  Description : Parametrised register file with registered reads,
//                write-to-read bypass and a per-register pending scoreboard.
//                Register 0 is hardwired to zero and never pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_file_sb #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NREAD-1:0]                 rd_req,
    input  logic [NREAD*$clog2(DEPTH)-1:0]   rd_addr,
    output logic [NREAD-1:0]                 rd_busy,
    output logic [NREAD-1:0]                 rd_valid,
    output logic [NREAD*WIDTH-1:0]           rd_data,
    input  logic                             wb_en,
    input  logic [$clog2(DEPTH)-1:0]         wb_addr,
    input  logic [WIDTH-1:0]                 wb_data,
    input  logic                             iss_en,
    input  logic [$clog2(DEPTH)-1:0]         iss_addr,
    output logic                             iss_busy,
    input  logic                             flush,
    output logic [DEPTH-1:0]                 pend_vec
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]       regs_q [DEPTH];
    logic [WIDTH-1:0]       regs_d [DEPTH];
    logic [DEPTH-1:0]       pend_q;
    logic [DEPTH-1:0]       pend_d;
    logic [NREAD-1:0]       rd_valid_q;
    logic [NREAD-1:0]       rd_valid_d;
    logic [NREAD*WIDTH-1:0] rd_data_q;
    logic [NREAD*WIDTH-1:0] rd_data_d;

    // Writeback and scoreboard next state; a same-cycle writeback releases a
    // pending destination, an accepted issue re-arms it, flush clears all.
    always_comb begin
        regs_d   = regs_q;
        pend_d   = pend_q;
        iss_busy = iss_en & pend_q[iss_addr] & ~(wb_en & (wb_addr == iss_addr)) & ~flush;
        if (wb_en && (wb_addr != '0)) begin
            regs_d[wb_addr] = wb_data;
        end
        if (wb_en) begin
            pend_d[wb_addr] = 1'b0;
        end
        if (iss_en && !iss_busy) begin
            pend_d[iss_addr] = 1'b1;
        end
        if (flush) begin
            pend_d = '0;
        end
        pend_d[0] = 1'b0;
    end

    // Read ports: busy on a pending target unless writeback resolves it now;
    // accepted reads sample the post-write value, giving the bypass for free.
    always_comb begin
        rd_busy    = '0;
        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        for (int i = 0; i < NREAD; i++) begin
            logic [AW-1:0] ra;
            ra         = rd_addr[i*AW +: AW];
            rd_busy[i] = rd_req[i] & pend_q[ra] & ~(wb_en & (wb_addr == ra));
            if (rd_req[i] && !rd_busy[i]) begin
                rd_valid_d[i]                 = 1'b1;
                rd_data_d[i*WIDTH +: WIDTH]   = regs_d[ra];
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            pend_q     <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
        end else begin
            regs_q     <= regs_d;
            pend_q     <= pend_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign pend_vec = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_sb
//  Description : Self-checking bench for reg_file_sb (default parameters).
//                Expected read results are queued when a read is driven and
//                popped when the registered outputs appear.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_sb;

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rd_req;
    logic [9:0]  rd_addr;
    logic [1:0]  rd_busy;
    logic [1:0]  rd_valid;
    logic [63:0] rd_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic        iss_busy;
    logic        flush;
    logic [31:0] pend_vec;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    reg_file_sb dut (
        .clk      (clk),
        .rst      (rst),
        .rd_req   (rd_req),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .iss_busy (iss_busy),
        .flush    (flush),
        .pend_vec (pend_vec)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle();
        rd_req   = '0;
        rd_addr  = '0;
        wb_en    = 1'b0;
        wb_addr  = '0;
        wb_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (rd_valid !== 2'b00 || rd_data !== 64'h0 || pend_vec !== 32'h0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b d=%h p=%h want 0/0/0", rd_valid, rd_data, pend_vec);
        end
        rst = 1'b0;
        rd_req  = 2'b11;
        rd_addr = {5'd0, 5'd5};
        sb.push_back('{valid: 2'b11, data: 64'h0});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL reset_read: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
        n_cmp++;
        if (pend_vec !== 32'h0) begin
            n_err++;
            $display("FAIL reset_pend: got %h want 0", pend_vec);
        end
    endtask

    task automatic test_write_read();
        exp_t e;
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEADBEEF;
        tick();
        idle();
        rd_req = 2'b01; rd_addr = {5'd0, 5'd3};
        sb.push_back('{valid: 2'b01, data: {32'h0, 32'hDEADBEEF}});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL write_then_read: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 32'h1234;
        rd_req = 2'b10; rd_addr = {5'd7, 5'd0};
        sb.push_back('{valid: 2'b10, data: {32'h1234, 32'hDEADBEEF}});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL bypass_read: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
    endtask

    task automatic test_scoreboard();
        exp_t e;
        iss_en = 1'b1; iss_addr = 5'd4;
        #1;
        n_cmp++;
        if (iss_busy !== 1'b0) begin
            n_err++;
            $display("FAIL issue_free: got %b want 0", iss_busy);
        end
        tick();
        idle();
        n_cmp++;
        if (pend_vec !== 32'h0000_0010) begin
            n_err++;
            $display("FAIL issue_pend: got %h want 00000010", pend_vec);
        end
        rd_req = 2'b01; rd_addr = {5'd0, 5'd4};
        iss_en = 1'b1; iss_addr = 5'd4;
        #1;
        n_cmp++;
        if (rd_busy !== 2'b01 || iss_busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_pending: got rb=%b ib=%b want rb=01 ib=1", rd_busy, iss_busy);
        end
        sb.push_back('{valid: 2'b00, data: {32'h1234, 32'hDEADBEEF}});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL refused_read: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h55;
        rd_req = 2'b01; rd_addr = {5'd0, 5'd4};
        #1;
        n_cmp++;
        if (rd_busy !== 2'b00) begin
            n_err++;
            $display("FAIL wb_unblocks_read: got %b want 00", rd_busy);
        end
        sb.push_back('{valid: 2'b01, data: {32'h1234, 32'h55}});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data || pend_vec !== 32'h0) begin
            n_err++;
            $display("FAIL wb_release: got v=%b d=%h p=%h want v=%b d=%h p=0", rd_valid, rd_data, pend_vec, e.valid, e.data);
        end
    endtask

    task automatic test_issue_wb_same();
        exp_t e;
        iss_en = 1'b1; iss_addr = 5'd9;
        wb_en  = 1'b1; wb_addr  = 5'd9; wb_data = 32'hA;
        tick();
        idle();
        n_cmp++;
        if (pend_vec !== 32'h0000_0200) begin
            n_err++;
            $display("FAIL issue_wins: got %h want 00000200", pend_vec);
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hB;
        tick();
        idle();
        n_cmp++;
        if (pend_vec !== 32'h0) begin
            n_err++;
            $display("FAIL wb_clears: got %h want 0", pend_vec);
        end
        rd_req = 2'b10; rd_addr = {5'd9, 5'd0};
        sb.push_back('{valid: 2'b10, data: {32'hB, 32'h55}});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL read_r9: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
        iss_en = 1'b1; iss_addr = 5'd4;
        tick();
        iss_en = 1'b1; iss_addr = 5'd4;
        wb_en  = 1'b1; wb_addr  = 5'd4; wb_data = 32'h66;
        #1;
        n_cmp++;
        if (iss_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reissue_with_wb: got %b want 0", iss_busy);
        end
        tick();
        idle();
        n_cmp++;
        if (pend_vec !== 32'h0000_0010) begin
            n_err++;
            $display("FAIL reissue_pend: got %h want 00000010", pend_vec);
        end
        wb_en = 1'b1; wb_addr = 5'd4; wb_data = 32'h77;
        tick();
        idle();
    endtask

    task automatic test_reg0();
        exp_t e;
        wb_en  = 1'b1; wb_addr  = 5'd0; wb_data = 32'hFFFF_FFFF;
        iss_en = 1'b1; iss_addr = 5'd0;
        #1;
        n_cmp++;
        if (iss_busy !== 1'b0) begin
            n_err++;
            $display("FAIL r0_iss_busy: got %b want 0", iss_busy);
        end
        tick();
        idle();
        n_cmp++;
        if (pend_vec !== 32'h0) begin
            n_err++;
            $display("FAIL r0_pend: got %h want 0", pend_vec);
        end
        rd_req = 2'b11; rd_addr = {5'd0, 5'd0};
        sb.push_back('{valid: 2'b11, data: 64'h0});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL r0_read: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
    endtask

    task automatic test_flush();
        iss_en = 1'b1; iss_addr = 5'd2;
        tick();
        iss_en = 1'b1; iss_addr = 5'd6;
        tick();
        idle();
        n_cmp++;
        if (pend_vec !== 32'h0000_0044) begin
            n_err++;
            $display("FAIL pend_two: got %h want 00000044", pend_vec);
        end
        flush = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd2;
        #1;
        n_cmp++;
        if (iss_busy !== 1'b0) begin
            n_err++;
            $display("FAIL flush_iss_busy: got %b want 0", iss_busy);
        end
        tick();
        idle();
        n_cmp++;
        if (pend_vec !== 32'h0) begin
            n_err++;
            $display("FAIL flush_pend: got %h want 0", pend_vec);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        rd_req = 2'b11; rd_addr = {5'd7, 5'd7};
        sb.push_back('{valid: 2'b11, data: {32'h1234, 32'h1234}});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL b2b_shared: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
        rd_req = 2'b11; rd_addr = {5'd9, 5'd3};
        sb.push_back('{valid: 2'b11, data: {32'hB, 32'hDEADBEEF}});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL b2b_split: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
    endtask

    task automatic test_async_reset();
        exp_t e;
        rd_req = 2'b01; rd_addr = {5'd0, 5'd3};
        sb.push_back('{valid: 2'b01, data: {32'hB, 32'hDEADBEEF}});
        tick();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL pre_reset_read: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
        #1;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (rd_valid !== 2'b00 || rd_data !== 64'h0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%h want 00/0", rd_valid, rd_data);
        end
        rst = 1'b0;
        idle();
        rd_req = 2'b01; rd_addr = {5'd0, 5'd3};
        sb.push_back('{valid: 2'b01, data: 64'h0});
        tick();
        idle();
        e = sb.pop_front();
        n_cmp++;
        if (rd_valid !== e.valid || rd_data !== e.data) begin
            n_err++;
            $display("FAIL post_reset_r3: got v=%b d=%h want v=%b d=%h", rd_valid, rd_data, e.valid, e.data);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_scoreboard();
        test_issue_wb_same();
        test_reg0();
        test_flush();
        test_back_to_back();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
